// File: rtl/fb_scanout.sv
// 1bpp framebuffer scan-out: raster timing, per-group RAM fetch over port Q1,
// and an MSB-first pixel shifter with sync, display-enable and frame indications.
module fb_scanout #(
  parameter logic [14:0] FB_BASE  = 15'h0000,
  parameter int          H_ACTIVE = 256,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 32,
  parameter int          H_BP     = 16,
  parameter int          V_ACTIVE = 192,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 58,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  input  logic        enable,
  output logic        Q1_CLOCK,
  output logic [14:0] Q1_ADDRESS,
  input  logic [7:0]  Q1_DATA_OUT,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pixel,
  output logic        vblank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_PF    = HW'(H_TOTAL - 8);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_GLAST = HW'(H_ACTIVE - 8);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [14:0]   STRIDE  = 15'(H_ACTIVE / 8);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [14:0]   line_base;
  logic          line_ok;
  logic [7:0]    shift_q;

  // stage p0: decode of the current raster position
  logic          h_last_p0, v_last_p0, line_act_p0, nxt_act_p0;
  logic          pf_pt_p0, grp_pt_p0, req_p0, ok_p0, load_p0;
  logic          de_p0, hs_p0, vs_p0;
  logic [VW-1:0] v_inc_p0;
  logic [14:0]   grp_p0;

  assign h_last_p0   = (h == H_LAST);
  assign v_last_p0   = (v == V_LAST);
  assign v_inc_p0    = v + VW'(1);
  assign line_act_p0 = (v < V_ACT);
  assign nxt_act_p0  = v_last_p0 ? 1'b1 : (v_inc_p0 < V_ACT);
  assign pf_pt_p0    = (h == H_PF);
  assign grp_pt_p0   = (h[2:0] == 3'd0) && (h < H_GLAST) && line_act_p0;
  assign req_p0      = pix_ce & enable & ((pf_pt_p0 & nxt_act_p0) | grp_pt_p0);
  assign grp_p0      = pf_pt_p0 ? 15'd0 : (15'(h >> 3) + 15'd1);
  assign load_p0     = (h[2:0] == 3'd7) || h_last_p0;
  assign de_p0       = (h < H_ACT) && line_act_p0;
  assign hs_p0       = (h >= HS_BEG) && (h < HS_END);
  assign vs_p0       = (v >= VS_BEG) && (v < VS_END);
  // A line is shown only if enable stayed high from its prefetch point onward.
  assign ok_p0       = pf_pt_p0 ? enable : (line_ok & enable);

  // stage p1: strobe/address and registered raster outputs; p2: fetched byte
  logic        vld_p1;
  logic [14:0] addr_p1;
  logic [7:0]  pbuf_p2;
  logic        de_p1, hs_p1, vs_p1, vb_p1, pix_p1, fs_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h         <= '0;
      v         <= '0;
      line_base <= FB_BASE;
      line_ok   <= 1'b1;
      shift_q   <= '0;
      vld_p1    <= 1'b0;
      addr_p1   <= FB_BASE;
      pbuf_p2   <= '0;
      de_p1     <= 1'b0;
      hs_p1     <= ~SYNC_POL;
      vs_p1     <= ~SYNC_POL;
      vb_p1     <= 1'b0;
      pix_p1    <= 1'b0;
      fs_p1     <= 1'b0;
    end else begin
      vld_p1 <= req_p0;
      if (req_p0) addr_p1 <= line_base + grp_p0;
      if (vld_p1) pbuf_p2 <= Q1_DATA_OUT;
      fs_p1 <= pix_ce & h_last_p0 & v_last_p0;
      if (pix_ce) begin
        h <= h_last_p0 ? '0 : h + HW'(1);
        if (h_last_p0) v <= v_last_p0 ? '0 : v_inc_p0;
        de_p1   <= de_p0;
        vb_p1   <= ~line_act_p0;
        hs_p1   <= hs_p0 ? SYNC_POL : ~SYNC_POL;
        vs_p1   <= vs_p0 ? SYNC_POL : ~SYNC_POL;
        pix_p1  <= shift_q[7] & de_p0 & ok_p0;
        line_ok <= ok_p0;
        shift_q <= load_p0 ? pbuf_p2 : {shift_q[6:0], 1'b0};
        // Held at the frame origin through blanking so the line-0 prefetch sees it.
        if (!line_act_p0)        line_base <= FB_BASE;
        else if (h == H_GLAST)   line_base <= line_base + STRIDE;
      end
    end
  end

  assign Q1_CLOCK    = vld_p1;
  assign Q1_ADDRESS  = addr_p1;
  assign hsync       = hs_p1;
  assign vsync       = vs_p1;
  assign de          = de_p1;
  assign pixel       = pix_p1;
  assign vblank      = vb_p1;
  assign frame_start = fs_p1;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a reduced raster; every clk is compared against a
// position-based reference model of timing, fetch addresses and pixel content.
module tb_fb_scanout;

  localparam logic [14:0] FB_BASE = 15'h7FF0;
  localparam int HA = 32, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 6, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int G = HA / 8;
  localparam logic POL = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic        enable = 1'b1;
  logic        Q1_CLOCK;
  logic [14:0] Q1_ADDRESS;
  logic [7:0]  Q1_DATA_OUT;
  logic        hsync, vsync, de, pixel, vblank, frame_start;

  logic [7:0] ram [0:32767];
  assign Q1_DATA_OUT = Q1_CLOCK ? ram[Q1_ADDRESS] : 8'hC3;

  fb_scanout #(
    .FB_BASE(FB_BASE), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .enable(enable),
    .Q1_CLOCK(Q1_CLOCK), .Q1_ADDRESS(Q1_ADDRESS), .Q1_DATA_OUT(Q1_DATA_OUT),
    .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel),
    .vblank(vblank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int n = 0;            // pix_ce steps since reset release = current raster position + 1
  int prev_pos = 0;     // position left by the most recent step
  int last_low = -1000; // last position stepped with enable=0
  bit stepped = 1'b0;
  int strobe_cnt = 0;
  bit win_clean = 1'b1;
  logic [15:0] cap = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_pix(input int p);
    int h, v;
    logic [14:0] a;
    logic [7:0] b;
    h = p % HT;
    v = (p / HT) % VT;
    // The first byte after reset has no prefetch behind it, so it shows blank.
    if (h >= HA || v >= VA || p < 8 || last_low >= p - h - 8) return 1'b0;
    a = 15'(int'(FB_BASE) + v * G + h / 8);
    b = ram[a];
    return b[7 - (h % 8)];
  endfunction

  function automatic logic is_req(input int q);
    int h, v;
    h = q % HT;
    v = (q / HT) % VT;
    return (h == HT - 8 && ((v + 1) % VT) < VA) || (h % 8 == 0 && h < HA - 8 && v < VA);
  endfunction

  function automatic logic [14:0] req_addr(input int q);
    int h, v;
    h = q % HT;
    v = (q / HT) % VT;
    if (h == HT - 8) return 15'(int'(FB_BASE) + ((v + 1) % VT) * G);
    return 15'(int'(FB_BASE) + v * G + h / 8 + 1);
  endfunction

  task automatic check();
    int p, h, v;
    logic e_de, e_hs, e_vs, e_vb, e_px, e_fs, e_st;
    if (n == 0) begin
      e_de = 1'b0; e_hs = ~POL; e_vs = ~POL; e_vb = 1'b0; e_px = 1'b0; e_fs = 1'b0;
      chk("q1_addr_rst", 32'(Q1_ADDRESS), 32'(FB_BASE));
    end else begin
      p = n - 1;
      h = p % HT;
      v = (p / HT) % VT;
      e_de = (h < HA) && (v < VA);
      e_hs = (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
      e_vs = (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
      e_vb = (v >= VA);
      e_px = exp_pix(p);
      e_fs = stepped && (n % FRAME == 0);
      if (p >= FRAME && p < FRAME + 16) cap[15 - (p - FRAME)] = pixel;
    end
    e_st = stepped && enable && (n > 0) && is_req(prev_pos);
    chk("de", 32'(de), 32'(e_de));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("vblank", 32'(vblank), 32'(e_vb));
    chk("pixel", 32'(pixel), 32'(e_px));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("q1_clock", 32'(Q1_CLOCK), 32'(e_st));
    if (e_st) chk("q1_addr", 32'(Q1_ADDRESS), 32'(req_addr(prev_pos)));
    if (Q1_CLOCK) strobe_cnt++;
    if (stepped && n > 0 && n % FRAME == 0) begin
      if (win_clean) chk("strobes_per_frame", 32'(strobe_cnt), 32'(VA * G));
      strobe_cnt = 0;
      win_clean = 1'b1;
    end
  endtask

  task automatic tick(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    stepped = ce;
    if (ce) begin
      if (!enable) begin
        last_low = n;
        win_clean = 1'b0;
      end
      prev_pos = n;
      n++;
    end
    #1;
    check();
  endtask

  task automatic model_reset();
    n = 0; prev_pos = 0; last_low = -1000; stepped = 1'b0;
    strobe_cnt = 0; win_clean = 1'b1; cap = '0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 8'($urandom);
    ram[FB_BASE] = 8'hA5;
    ram[15'(FB_BASE + 15'd1)] = 8'hFF;

    // reset state, then idle clks with no pixel steps
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check();
    rst_n = 1'b1;
    tick(1'b0);
    tick(1'b0);

    // pix_ce every clk
    repeat (2 * FRAME + 20) tick(1'b1);
    chk("line0_pattern", 32'(cap), 32'h0000A5FF);

    // pix_ce every third clk
    repeat (FRAME + 10) begin
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
    end

    // irregular pix_ce
    repeat (2 * FRAME) tick(1'($urandom_range(0, 1)));

    // scan-out disabled for more than a frame, re-enabled mid-line
    enable = 1'b0;
    repeat (FRAME + HT + int'($urandom_range(0, HT - 1))) tick(1'b1);
    enable = 1'b1;
    repeat (2 * FRAME) tick(1'b1);

    // enable flickering with irregular pix_ce
    repeat (600) begin
      enable = ($urandom_range(0, 15) != 0);
      tick(1'($urandom_range(0, 1)));
    end
    enable = 1'b1;
    repeat (2 * FRAME) tick(1'b1);

    // reset while a strobe is in flight (line 4, group fetch at h=16)
    for (int k = 0; k < 2 * FRAME && (n == 0 || (n - 1) % FRAME != 4 * HT + 16); k++) tick(1'b1);
    chk("strobe_before_reset", 32'(Q1_CLOCK), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check();
    @(posedge clk);
    #1;
    check();
    rst_n = 1'b1;
    repeat (2 * FRAME + 20) tick(1'b1);
    chk("line0_after_reset", 32'(cap), 32'h0000A5FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
